// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ============================================================================
// Module   : nibble_serial_adder_ctrl_pkg
// Purpose  : Shared types and constants for the nibble-serial adder sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index counter must be at least one bit, even for a single-nibble operand.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_add4_carry.sv
// ============================================================================
// Module   : add4_carry
// Purpose  : Combinational 4-bit ripple adder with carry-in; sum[4] is carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add4_carry
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W:0]   sum
);

    logic [NIBBLE_W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
    end

    assign sum[NIBBLE_W] = w_carry[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Adds two wide operands one nibble per cycle, LSB first, with a
//            registered carry and valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic [1:0]             clock_reset,
    input  logic [4*NIBBLES-1:0]   a_data,
    input  logic [4*NIBBLES-1:0]   b_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*NIBBLES:0]     out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    logic clk;
    logic rst;

    assign clk = clock_reset[0];
    assign rst = clock_reset[1];

    state_t           state_q,     state_d;
    logic [W-1:0]     a_q,         a_d;
    logic [W-1:0]     b_q,         b_d;
    logic [W:0]       result_q,    result_d;
    logic             carry_q,     carry_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic [NIBBLE_W:0]   w_nib_sum;

    assign w_nib_a = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign w_nib_b = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    add4_carry u_add4_carry (
        .a   (w_nib_a),
        .b   (w_nib_b),
        .cin (carry_q),
        .sum (w_nib_sum)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a_data;
                    b_d      = b_data;
                    carry_d  = 1'b0;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = w_nib_sum[NIBBLE_W-1:0];
                carry_d = w_nib_sum[NIBBLE_W];
                if (idx_q == C_LAST_IDX) begin
                    result_d[W] = w_nib_sum[NIBBLE_W];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                // New pairs are only taken from IDLE, so in_valid is not looked at here.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = result_q;

endmodule

`default_nettype wire
